// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one shared single-cycle memory port.
// Data wins by default; a fetch that has waited STARVE_LIMIT cycles takes the port.
//
// state   | meaning
// NONE    | no read response this cycle
// RESP_IF | mem_rdata belongs to the fetch read granted last cycle
// RESP_D  | mem_rdata belongs to the data load granted last cycle
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_ena,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic       MEM_READ = 1'b0;
  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } resp_state_t;

  resp_state_t state, state_nxt;
  logic [2:0]  starve_cnt, starve_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= NONE;
      starve_cnt <= 3'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Everything is gated by rst so outputs read zero throughout reset.
  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = 32'd0;
    d_rvalid   = 1'b0;
    d_rdata    = 32'd0;
    mem_ena    = 1'b0;
    mem_rw     = MEM_READ;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_wmask  = 4'd0;
    stall_if   = 1'b0;
    stall_mem  = 1'b0;
    state_nxt  = NONE;
    starve_nxt = 3'd0;

    if (rst) begin
      if (if_req && starve_cnt == LIMIT) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end

      if (if_gnt) begin
        mem_ena  = 1'b1;
        mem_addr = if_addr;
      end else if (d_gnt) begin
        mem_ena   = 1'b1;
        mem_rw    = d_rw;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wmask = d_wmask;
      end

      case (state)
        RESP_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        RESP_D: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase

      if (if_gnt) begin
        state_nxt = RESP_IF;
      end else if (d_gnt && d_rw == MEM_READ) begin
        state_nxt = RESP_D;
      end

      if (if_req && !if_gnt) begin
        starve_nxt = (starve_cnt < LIMIT) ? starve_cnt + 3'd1 : starve_cnt;
      end

      stall_if  = if_req & ~if_gnt;
      stall_mem = d_req & ~d_gnt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_rw;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ena, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: how long fetch has waited, and who owns next cycle's read data.
  int m_starve  = 0;
  int m_pending = 0; // 0 none, 1 fetch, 2 data
  logic m_if_gnt = 1'b0;
  logic m_d_gnt  = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ena(mem_ena), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [139:0] dut_vec();
    return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            mem_ena, mem_rw, mem_addr, mem_wdata, mem_wmask, stall_if, stall_mem};
  endfunction

  function automatic logic fetch_wins();
    return if_req && (m_starve >= LIMIT || !d_req);
  endfunction

  function automatic logic [139:0] exp_vec();
    logic eig = 0, edg = 0, eiv = 0, edv = 0, een = 0, erw = 0, esi = 0, esm = 0;
    logic [31:0] eir = 0, edr = 0, ead = 0, ewd = 0;
    logic [3:0]  ewm = 0;
    if (rst) begin
      eig = fetch_wins();
      edg = d_req && !eig;
      if (eig) begin
        een = 1; ead = if_addr;
      end else if (edg) begin
        een = 1; erw = d_rw; ead = d_addr; ewd = d_wdata; ewm = d_wmask;
      end
      eiv = (m_pending == 1);
      edv = (m_pending == 2);
      if (eiv) eir = mem_rdata;
      if (edv) edr = mem_rdata;
      esi = if_req && !eig;
      esm = d_req && !edg;
    end
    return {eig, eiv, eir, edg, edv, edr, een, erw, ead, ewd, ewm, esi, esm};
  endfunction

  // Advance one clock, moving the model across the same edge.
  task automatic step();
    if (!rst) begin
      m_starve = 0; m_pending = 0; m_if_gnt = 0; m_d_gnt = 0;
    end else begin
      m_if_gnt  = fetch_wins();
      m_d_gnt   = d_req && !m_if_gnt;
      m_pending = m_if_gnt ? 1 : ((m_d_gnt && !d_rw) ? 2 : 0);
      m_starve  = (if_req && !m_if_gnt) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_rw = 0;
    d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = $urandom;
    #2;
    n_tests++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL idle: got %h want %h", dut_vec(), exp_vec());
    end
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst = 0; if_req = 1'($urandom); d_req = 1'($urandom); d_rw = 1'($urandom);
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_wmask = 4'($urandom); mem_rdata = $urandom;
      #2;
      n_tests++;
      if (dut_vec() !== 140'd0) begin
        n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
      end
      step();
    end
  endtask

  task automatic test_fetch_single();
    idle();
    if_req = 1; if_addr = 32'h100;
    #2;
    n_tests++;
    if ({if_gnt, mem_ena, mem_rw, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
      n_fail++; $display("FAIL fetch_grant: got %b %b %b %h want 1 1 0 00000100",
                         if_gnt, mem_ena, mem_rw, mem_addr);
    end
    step();
    if_req = 0; mem_rdata = 32'hDEADBEEF;
    #2;
    n_tests++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL fetch_resp: got %b %h want 1 deadbeef", if_rvalid, if_rdata);
    end
    step();
  endtask

  task automatic test_priority();
    idle();
    if_req = 1; if_addr = 32'h300; d_req = 1; d_rw = 0; d_addr = 32'h200;
    #2;
    n_tests++;
    if ({d_gnt, if_gnt, stall_if, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h200}) begin
      n_fail++; $display("FAIL prio_c0: got %b %b %b %h want 1 0 1 00000200",
                         d_gnt, if_gnt, stall_if, mem_addr);
    end
    step();
    d_req = 0; mem_rdata = 32'hA5A5_0001;
    #2;
    n_tests++;
    if ({d_rvalid, d_rdata, if_gnt, if_rvalid} !== {1'b1, 32'hA5A5_0001, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL prio_c1: got %b %h %b %b want 1 a5a50001 1 0",
                         d_rvalid, d_rdata, if_gnt, if_rvalid);
    end
    step();
  endtask

  task automatic test_starvation();
    logic [5:0] want_d = 6'b101111; // bit i = d_gnt expected in cycle i
    idle();
    if_req = 1; if_addr = 32'h500; d_req = 1; d_rw = 1; d_addr = 32'h80;
    d_wdata = 32'h1; d_wmask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_tests++;
      if ({d_gnt, if_gnt, stall_mem} !== {want_d[i], ~want_d[i], ~want_d[i]}) begin
        n_fail++; $display("FAIL starve_c%0d: got d=%b if=%b sm=%b want d=%b",
                           i, d_gnt, if_gnt, stall_mem, want_d[i]);
      end
      step();
    end
  endtask

  task automatic test_store();
    idle();
    d_req = 1; d_rw = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_wmask = 4'b0011;
    #2;
    n_tests++;
    if ({d_gnt, mem_ena, mem_rw, mem_addr, mem_wdata, mem_wmask} !==
        {1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011}) begin
      n_fail++; $display("FAIL store: got %b %b %b %h %h %b", d_gnt, mem_ena, mem_rw,
                         mem_addr, mem_wdata, mem_wmask);
    end
    step();
    d_req = 0; mem_rdata = 32'hFFFF_FFFF;
    #2;
    n_tests++;
    if ({d_rvalid, if_rvalid, d_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL store_no_rvalid: got %b %b %h want 0 0 0", d_rvalid, if_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    idle();
    for (int i = 0; i < 4; i++) begin
      if_req = (i < 3); if_addr = 32'h1000 + 32'(i);
      if (i > 0) begin
        data[i-1] = $urandom; mem_rdata = data[i-1];
      end
      #2;
      if (i < 3) begin
        n_tests++;
        if (!if_gnt || mem_addr !== 32'h1000 + 32'(i)) begin
          n_fail++; $display("FAIL b2b_gnt%0d: got %b %h", i, if_gnt, mem_addr);
        end
      end
      if (i > 0) begin
        n_tests++;
        if ({if_rvalid, if_rdata} !== {1'b1, data[i-1]}) begin
          n_fail++; $display("FAIL b2b_resp%0d: got %b %h want 1 %h", i, if_rvalid, if_rdata, data[i-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read();
    idle();
    d_req = 1; d_rw = 0; d_addr = 32'h700;
    #2;
    n_tests++;
    if (d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmr_grant: got %b want 1", d_gnt);
    end
    step();
    rst = 0; d_req = 1; if_req = 1; mem_rdata = 32'hCAFE_F00D;
    #2;
    n_tests++;
    if (dut_vec() !== 140'd0) begin
      n_fail++; $display("FAIL rmr_in_reset: got %h want 0", dut_vec());
    end
    step();
    rst = 1; if_req = 0; d_req = 1; d_addr = 32'h704;
    #2;
    n_tests++;
    if ({d_rvalid, d_gnt, mem_addr} !== {1'b0, 1'b1, 32'h704}) begin
      n_fail++; $display("FAIL rmr_after: got rv=%b g=%b %h want 0 1 00000704", d_rvalid, d_gnt, mem_addr);
    end
    step();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      // Requesters keep req and payload stable until granted.
      if (!(if_req && !m_if_gnt) || !rst) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
      end
      if (!(d_req && !m_d_gnt) || !rst) begin
        d_req = ($urandom_range(0, 2) != 0); d_rw = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_wmask = 4'($urandom);
      end
      rst = ($urandom_range(0, 39) != 0);
      mem_rdata = $urandom;
      #2;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      step();
    end
  endtask

  initial begin
    rst = 0; if_req = 0; if_addr = 0; d_req = 0; d_rw = 0;
    d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0;
    #1;
    test_reset();
    test_fetch_single();
    test_priority();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
